// File: rtl/ram_access_scheduler.sv
// Two-requester scheduler for the RAM write port and read port B.
// Byte-masked writes use read-modify-write. Optional lock: RAM_SCHED_LOCK_EN.
module ram_access_scheduler #(
    parameter int RAM_A_WIDTH = 12
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  logic                   req0_write,
    input  logic [RAM_A_WIDTH-1:0] req0_address,
    input  logic [31:0]            req0_wdata,
    input  logic [3:0]             req0_byteEnable,
    output logic                   resp0_valid,
    output logic [31:0]            resp0_rdata,
    input  logic                   req1_valid,
    output logic                   req1_ready,
    input  logic                   req1_write,
    input  logic [RAM_A_WIDTH-1:0] req1_address,
    input  logic [31:0]            req1_wdata,
    input  logic [3:0]             req1_byteEnable,
    output logic                   resp1_valid,
    output logic [31:0]            resp1_rdata,
`ifdef RAM_SCHED_LOCK_EN
    input  logic                   req0_lock,
    input  logic                   req1_lock,
`endif
    output logic [RAM_A_WIDTH-1:0] ram_writeAddress,
    output logic [31:0]            ram_dataIn,
    output logic                   ram_writeEnable,
    output logic [RAM_A_WIDTH-1:0] ram_readAddressB,
    input  logic [31:0]            ram_dataOutB
);

    typedef enum logic [1:0] {
        IDLE,
        RD_DATA,
        RMW_MERGE,
        WR_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic                   ptr_q, ptr_d;
    logic                   sel_q, sel_d;
    logic [RAM_A_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [3:0]             be_q, be_d;
    logic [31:0]            rdata0_q, rdata0_d;
    logic [31:0]            rdata1_q, rdata1_d;
`ifdef RAM_SCHED_LOCK_EN
    logic                   lock_q, lock_d;
    logic                   g_lock;
`endif

    logic                   g0, g1, gsel;
    logic                   g_write;
    logic [RAM_A_WIDTH-1:0] g_addr;
    logic [31:0]            g_wdata;
    logic [3:0]             g_be;
    logic [31:0]            merged;
    logic                   rsp_valid;
    logic [31:0]            rsp_data;

    // Arbitration, request mux, next state and all RAM/response outputs
    always_comb begin
        state_d          = state_q;
        ptr_d            = ptr_q;
        sel_d            = sel_q;
        addr_d           = addr_q;
        wdata_d          = wdata_q;
        be_d             = be_q;
        req0_ready       = 1'b0;
        req1_ready       = 1'b0;
        ram_writeAddress = '0;
        ram_dataIn       = '0;
        ram_writeEnable  = 1'b0;
        ram_readAddressB = '0;
        rsp_valid        = 1'b0;
        rsp_data         = '0;
        merged           = '0;
`ifdef RAM_SCHED_LOCK_EN
        lock_d = lock_q;
        if (lock_q) begin
            g0 = req0_valid && !sel_q;
            g1 = req1_valid && sel_q;
        end else begin
            g0 = req0_valid && (!req1_valid || !ptr_q);
            g1 = req1_valid && (!req0_valid || ptr_q);
        end
        g_lock = g1 ? req1_lock : req0_lock;
`else
        g0 = req0_valid && (!req1_valid || !ptr_q);
        g1 = req1_valid && (!req0_valid || ptr_q);
`endif
        gsel    = g1;
        g_write = g1 ? req1_write : req0_write;
        g_addr  = g1 ? req1_address : req0_address;
        g_wdata = g1 ? req1_wdata : req0_wdata;
        g_be    = g1 ? req1_byteEnable : req0_byteEnable;

        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8]
                                       : ram_dataOutB[8*i +: 8];
        end

        unique case (state_q)
            IDLE: begin
                // Gate on reset so nothing is granted or written while held.
                if (reset && (g0 || g1)) begin
                    req0_ready = g0;
                    req1_ready = g1;
                    sel_d      = gsel;
                    addr_d     = g_addr;
                    wdata_d    = g_wdata;
                    be_d       = g_be;
`ifdef RAM_SCHED_LOCK_EN
                    lock_d = g_lock;
                    ptr_d  = g_lock ? ptr_q : ~gsel;
`else
                    ptr_d = ~gsel;
`endif
                    if (!g_write) begin
                        ram_readAddressB = g_addr;
                        state_d          = RD_DATA;
                    end else if (g_be == 4'b1111) begin
                        ram_writeEnable  = 1'b1;
                        ram_writeAddress = g_addr;
                        ram_dataIn       = g_wdata;
                        state_d          = WR_DONE;
                    end else if (g_be == 4'b0000) begin
                        state_d = WR_DONE;
                    end else begin
                        ram_readAddressB = g_addr;
                        state_d          = RMW_MERGE;
                    end
                end
            end
            RD_DATA: begin
                rsp_valid = 1'b1;
                rsp_data  = ram_dataOutB;
                state_d   = IDLE;
            end
            RMW_MERGE: begin
                ram_writeEnable  = 1'b1;
                ram_writeAddress = addr_q;
                ram_dataIn       = merged;
                state_d          = WR_DONE;
            end
            WR_DONE: begin
                rsp_valid = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        resp0_valid = rsp_valid && !sel_q;
        resp1_valid = rsp_valid && sel_q;
        resp0_rdata = resp0_valid ? rsp_data : rdata0_q;
        resp1_rdata = resp1_valid ? rsp_data : rdata1_q;
        rdata0_d    = resp0_rdata;
        rdata1_d    = resp1_rdata;
    end

    // State, pointer, captured request and held response data
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            ptr_q    <= 1'b0;
            sel_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
`ifdef RAM_SCHED_LOCK_EN
            lock_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            sel_q    <= sel_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
`ifdef RAM_SCHED_LOCK_EN
            lock_q   <= lock_d;
`endif
        end
    end

endmodule

// File: tb/tb_ram_access_scheduler.sv
// Directed bench for ram_access_scheduler with a behavioural word RAM.
// Lock scenario runs only when RAM_SCHED_LOCK_EN is defined.
module tb_ram_access_scheduler;
    localparam int AW = 12;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic          req0_valid, req0_ready, req0_write;
    logic [AW-1:0] req0_address;
    logic [31:0]   req0_wdata;
    logic [3:0]    req0_byteEnable;
    logic          resp0_valid;
    logic [31:0]   resp0_rdata;
    logic          req1_valid, req1_ready, req1_write;
    logic [AW-1:0] req1_address;
    logic [31:0]   req1_wdata;
    logic [3:0]    req1_byteEnable;
    logic          resp1_valid;
    logic [31:0]   resp1_rdata;
    logic          req0_lock, req1_lock;
    logic [AW-1:0] ram_wa, ram_ra;
    logic [31:0]   ram_din, ram_dout;
    logic          ram_we;

    logic [31:0] mem [0:(1<<AW)-1];

    // Word RAM with one-cycle registered read on port B
    always @(posedge clock) begin
        if (ram_we) mem[ram_wa] <= ram_din;
        ram_dout <= mem[ram_ra];
    end

    ram_access_scheduler #(.RAM_A_WIDTH(AW)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_write(req0_write), .req0_address(req0_address),
        .req0_wdata(req0_wdata), .req0_byteEnable(req0_byteEnable),
        .resp0_valid(resp0_valid), .resp0_rdata(resp0_rdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_write(req1_write), .req1_address(req1_address),
        .req1_wdata(req1_wdata), .req1_byteEnable(req1_byteEnable),
        .resp1_valid(resp1_valid), .resp1_rdata(resp1_rdata),
`ifdef RAM_SCHED_LOCK_EN
        .req0_lock(req0_lock), .req1_lock(req1_lock),
`endif
        .ram_writeAddress(ram_wa), .ram_dataIn(ram_din),
        .ram_writeEnable(ram_we), .ram_readAddressB(ram_ra),
        .ram_dataOutB(ram_dout)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic idle_reqs();
        req0_valid = 0; req0_write = 0; req0_address = '0;
        req0_wdata = '0; req0_byteEnable = '0; req0_lock = 0;
        req1_valid = 0; req1_write = 0; req1_address = '0;
        req1_wdata = '0; req1_byteEnable = '0; req1_lock = 0;
    endtask

    task automatic test_reset();
        idle_reqs();
        @(negedge clock);
        req0_valid = 1; req0_write = 1; req0_address = 12'h005;
        req0_wdata = 32'h12345678; req0_byteEnable = 4'hF;
        #1;
        n_chk++; if (req0_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready0 got %b want 0", req0_ready); end
        n_chk++; if (resp0_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp0 got %b want 0", resp0_valid); end
        n_chk++; if (resp1_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp1 got %b want 0", resp1_valid); end
        n_chk++; if (resp0_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata0 got %h want 0", resp0_rdata); end
        n_chk++; if (resp1_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata1 got %h want 0", resp1_rdata); end
        n_chk++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL rst_we got %b want 0", ram_we); end
        n_chk++; if (ram_wa !== '0 || ram_ra !== '0 || ram_din !== '0) begin n_fail++; $display("FAIL rst_ram got wa=%h ra=%h din=%h want 0", ram_wa, ram_ra, ram_din); end
        idle_reqs();
        @(negedge clock);
        reset = 1;
    endtask

    task automatic test_read_full_write();
        @(negedge clock);
        req0_valid = 1; req0_write = 1; req0_address = 12'h010;
        req0_wdata = 32'hDEADBEEF; req0_byteEnable = 4'hF;
        #1;
        n_chk++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin n_fail++; $display("FAIL fw_ready got %b%b want 10", req0_ready, req1_ready); end
        n_chk++; if (ram_we !== 1'b1 || ram_wa !== 12'h010 || ram_din !== 32'hDEADBEEF) begin n_fail++; $display("FAIL fw_ram got we=%b wa=%h din=%h want 1 010 deadbeef", ram_we, ram_wa, ram_din); end
        @(negedge clock);
        idle_reqs();
        #1;
        n_chk++; if (resp0_valid !== 1'b1 || resp0_rdata !== 32'h0) begin n_fail++; $display("FAIL fw_resp got v=%b d=%h want 1 0", resp0_valid, resp0_rdata); end
        n_chk++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL fw_we_after got %b want 0", ram_we); end
        @(negedge clock);
        req0_valid = 1; req0_write = 0; req0_address = 12'h010;
        #1;
        n_chk++; if (req0_ready !== 1'b1 || ram_ra !== 12'h010) begin n_fail++; $display("FAIL rd_accept got rdy=%b ra=%h want 1 010", req0_ready, ram_ra); end
        n_chk++; if (resp0_valid !== 1'b0) begin n_fail++; $display("FAIL rd_early got %b want 0", resp0_valid); end
        @(negedge clock);
        idle_reqs();
        #1;
        n_chk++; if (resp0_valid !== 1'b1 || resp0_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_resp got v=%b d=%h want 1 deadbeef", resp0_valid, resp0_rdata); end
        @(negedge clock);
        #1;
        n_chk++; if (resp0_valid !== 1'b0 || resp0_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_hold got v=%b d=%h want 0 deadbeef", resp0_valid, resp0_rdata); end
    endtask

    task automatic test_partial_write();
        @(negedge clock);
        mem[12'h020] = 32'h11223344;
        req1_valid = 1; req1_write = 1; req1_address = 12'h020;
        req1_wdata = 32'hAABBCCDD; req1_byteEnable = 4'b0101;
        #1;
        n_chk++; if (req1_ready !== 1'b1 || ram_we !== 1'b0 || ram_ra !== 12'h020) begin n_fail++; $display("FAIL pw_accept got rdy=%b we=%b ra=%h want 1 0 020", req1_ready, ram_we, ram_ra); end
        @(negedge clock);
        idle_reqs();
        #1;
        n_chk++; if (ram_we !== 1'b1 || ram_wa !== 12'h020 || ram_din !== 32'h11BB33DD) begin n_fail++; $display("FAIL pw_merge got we=%b wa=%h din=%h want 1 020 11bb33dd", ram_we, ram_wa, ram_din); end
        n_chk++; if (resp1_valid !== 1'b0) begin n_fail++; $display("FAIL pw_early got %b want 0", resp1_valid); end
        @(negedge clock);
        #1;
        n_chk++; if (resp1_valid !== 1'b1 || ram_we !== 1'b0) begin n_fail++; $display("FAIL pw_resp got v=%b we=%b want 1 0", resp1_valid, ram_we); end
        @(negedge clock);
        req1_valid = 1; req1_write = 0; req1_address = 12'h020;
        #1;
        n_chk++; if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL pw_rd_accept got %b want 1", req1_ready); end
        @(negedge clock);
        idle_reqs();
        #1;
        n_chk++; if (resp1_valid !== 1'b1 || resp1_rdata !== 32'h11BB33DD) begin n_fail++; $display("FAIL pw_rd_resp got v=%b d=%h want 1 11bb33dd", resp1_valid, resp1_rdata); end
    endtask

    task automatic test_contention();
        @(negedge clock);
        reset = 0;
        req0_valid = 1; req0_write = 0; req0_address = 12'h010;
        req1_valid = 1; req1_write = 0; req1_address = 12'h020;
        @(negedge clock);
        reset = 1;
        for (int c = 0; c < 8; c++) begin
            #1;
            n_chk++; if (req0_ready !== (c % 4 == 0) || req1_ready !== (c % 4 == 2)) begin n_fail++; $display("FAIL arb_c%0d got rdy=%b%b want %b%b", c, req0_ready, req1_ready, c % 4 == 0, c % 4 == 2); end
            n_chk++; if (resp0_valid !== (c % 4 == 1) || resp1_valid !== (c % 4 == 3)) begin n_fail++; $display("FAIL arb_resp_c%0d got %b%b want %b%b", c, resp0_valid, resp1_valid, c % 4 == 1, c % 4 == 3); end
            if (c % 4 == 1) begin
                n_chk++; if (resp0_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL arb_d0_c%0d got %h want deadbeef", c, resp0_rdata); end
            end
            if (c % 4 == 3) begin
                n_chk++; if (resp1_rdata !== 32'h11BB33DD) begin n_fail++; $display("FAIL arb_d1_c%0d got %h want 11bb33dd", c, resp1_rdata); end
            end
            @(negedge clock);
        end
        idle_reqs();
    endtask

    task automatic test_empty_mask();
        @(negedge clock);
        mem[12'h030] = 32'h00000055;
        req0_valid = 1; req0_write = 1; req0_address = 12'h030;
        req0_wdata = 32'hFFFFFFFF; req0_byteEnable = 4'b0000;
        #1;
        n_chk++; if (req0_ready !== 1'b1 || ram_we !== 1'b0) begin n_fail++; $display("FAIL em_accept got rdy=%b we=%b want 1 0", req0_ready, ram_we); end
        @(negedge clock);
        idle_reqs();
        #1;
        n_chk++; if (resp0_valid !== 1'b1 || ram_we !== 1'b0) begin n_fail++; $display("FAIL em_resp got v=%b we=%b want 1 0", resp0_valid, ram_we); end
        @(negedge clock);
        req0_valid = 1; req0_write = 0; req0_address = 12'h030;
        #1;
        n_chk++; if (req0_ready !== 1'b1 || ram_we !== 1'b0) begin n_fail++; $display("FAIL em_rd_accept got rdy=%b we=%b want 1 0", req0_ready, ram_we); end
        @(negedge clock);
        idle_reqs();
        #1;
        n_chk++; if (resp0_valid !== 1'b1 || resp0_rdata !== 32'h55) begin n_fail++; $display("FAIL em_rd_resp got v=%b d=%h want 1 55", resp0_valid, resp0_rdata); end
    endtask

    task automatic test_reset_mid_rmw();
        @(negedge clock);
        mem[12'h040] = 32'hCAFEF00D;
        req0_valid = 1; req0_write = 1; req0_address = 12'h040;
        req0_wdata = 32'h12345678; req0_byteEnable = 4'b0011;
        #1;
        n_chk++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL rr_accept got %b want 1", req0_ready); end
        @(negedge clock);
        idle_reqs();
        #1;
        n_chk++; if (ram_we !== 1'b1 || ram_din !== 32'hCAFE5678) begin n_fail++; $display("FAIL rr_merge got we=%b din=%h want 1 cafe5678", ram_we, ram_din); end
        reset = 0;
        #1;
        n_chk++; if (ram_we !== 1'b0 || resp0_valid !== 1'b0) begin n_fail++; $display("FAIL rr_drop got we=%b v=%b want 0 0", ram_we, resp0_valid); end
        @(negedge clock);
        n_chk++; if (mem[12'h040] !== 32'hCAFEF00D) begin n_fail++; $display("FAIL rr_mem got %h want cafef00d", mem[12'h040]); end
        reset = 1;
        @(negedge clock);
        req0_valid = 1; req0_write = 0; req0_address = 12'h040;
        #1;
        n_chk++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL rr_idle got %b want 1", req0_ready); end
        @(negedge clock);
        idle_reqs();
        #1;
        n_chk++; if (resp0_valid !== 1'b1 || resp0_rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL rr_read got v=%b d=%h want 1 cafef00d", resp0_valid, resp0_rdata); end
    endtask

`ifdef RAM_SCHED_LOCK_EN
    task automatic test_lock();
        @(negedge clock);
        reset = 0;
        req0_valid = 1; req0_write = 0; req0_address = 12'h010; req0_lock = 1;
        req1_valid = 1; req1_write = 0; req1_address = 12'h020;
        @(negedge clock);
        reset = 1;
        #1;
        n_chk++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin n_fail++; $display("FAIL lk_c0 got %b%b want 10", req0_ready, req1_ready); end
        @(negedge clock);
        @(negedge clock);
        #1;
        n_chk++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin n_fail++; $display("FAIL lk_c2 got %b%b want 10", req0_ready, req1_ready); end
        @(negedge clock);
        @(negedge clock);
        req0_lock = 0;
        #1;
        n_chk++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin n_fail++; $display("FAIL lk_c4 got %b%b want 10", req0_ready, req1_ready); end
        @(negedge clock);
        req0_valid = 0;
        #1;
        n_chk++; if (resp0_valid !== 1'b1 || req1_ready !== 1'b0) begin n_fail++; $display("FAIL lk_c5 got v=%b r1=%b want 1 0", resp0_valid, req1_ready); end
        @(negedge clock);
        #1;
        n_chk++; if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL lk_c6 got %b want 1", req1_ready); end
        @(negedge clock);
        idle_reqs();
        #1;
        n_chk++; if (resp1_valid !== 1'b1 || resp1_rdata !== 32'h11BB33DD) begin n_fail++; $display("FAIL lk_resp1 got v=%b d=%h want 1 11bb33dd", resp1_valid, resp1_rdata); end
    endtask
`endif

    initial begin
        test_reset();
        test_read_full_write();
        test_partial_write();
        test_contention();
        test_empty_mask();
        test_reset_mid_rmw();
`ifdef RAM_SCHED_LOCK_EN
        test_lock();
`endif
        @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
